// File: rtl/boot_sequencer.sv
// Power-up / reload sequencer for the RV32 core: receives a length-prefixed byte
// image, packs it into little-endian words, writes instruction memory, then releases the core.
module boot_sequencer #(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    input  logic               start,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               core_rset,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {HDR, LOAD, FLUSH, RUN, ERR} state_t;

    localparam logic [31:0] MAX_LEN = 32'd1 << IMEM_AW;

    state_t             state;
    logic [1:0]         byte_cnt;
    logic [IMEM_AW:0]   word_cnt;
    logic [31:0]        len;
    logic [23:0]        shift;
    logic [31:0]        word_p0;
    logic               vld_p0;
    logic               rx_fire;
    logic               last_word;
    logic [31:0]        len_next;

    function automatic logic len_ok(input logic [31:0] l);
        return (l != 32'd0) && (l <= MAX_LEN);
    endfunction

    assign rx_ready  = (state == HDR) || (state == LOAD);
    assign core_rset = (state != RUN);
    assign busy      = (state == HDR) || (state == LOAD) || (state == FLUSH);
    assign done      = (state == RUN);
    assign err       = (state == ERR);

    assign rx_fire   = rx_valid && rx_ready;
    assign len_next  = {rx_data, len[31:8]};
    assign last_word = ({{(31-IMEM_AW){1'b0}}, word_cnt} == (len - 32'd1));

    // Stage p0: byte assembly; the word register is pure datapath and carries no reset
    always_ff @(posedge clk) begin
        if (rx_fire && (state == LOAD)) begin
            shift <= {rx_data, shift[23:8]};
            if (byte_cnt == 2'd3) begin
                word_p0 <= {rx_data, shift};
            end
        end
    end

    // Stage p1: memory write one edge after the 4th byte, plus sequencing control
    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            state      <= HDR;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            len        <= '0;
            vld_p0     <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            vld_p0  <= 1'b0;
            if (vld_p0) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_cnt[IMEM_AW-1:0];
                imem_wdata <= word_p0;
                word_cnt   <= word_cnt + 1'b1;
            end
            case (state)
                HDR: begin
                    if (rx_fire) begin
                        len      <= len_next;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            state <= len_ok(len_next) ? LOAD : ERR;
                        end
                    end
                end
                LOAD: begin
                    if (rx_fire) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            vld_p0 <= 1'b1;
                            if (last_word) begin
                                state <= FLUSH;
                            end
                        end
                    end
                end
                // Hold the core in reset until the final word has left the write stage
                FLUSH: begin
                    if (!vld_p0) begin
                        state <= RUN;
                    end
                end
                RUN, ERR: begin
                    if (start) begin
                        state    <= HDR;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                        len      <= '0;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule
